// File: rtl/vslc_scan_sequencer.sv
// VSLC scan sequencer: sample, strobe/exec per instruction, commit, wait.
// Optional single-step scans enabled by defining VSLC_SINGLE_STEP_EN.
module vslc_scan_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int PROG_LEN    = 16,
  parameter int PERIOD_W    = 16,
  parameter int SCAN_PERIOD = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              run,
  input  logic              step_req,
  input  logic [7:0]        in_pins,
  input  logic              instr_done,
  output logic [7:0]        in_latched,
  output logic [ADDR_W-1:0] pc,
  output logic              addr_strobe,
  output logic              out_latch_en,
  output logic              scan_cycle_clk,
  output logic              scan_overrun,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, STROBE, EXEC, COMMIT, WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(PROG_LEN - 1);
  localparam logic [PERIOD_W-1:0] TERM =
    PERIOD_W'(SCAN_PERIOD - 1);

  state_t              state, nxt;
  logic [PERIOD_W-1:0] cnt;
  logic                step_mode;
  logic                late;

  assign late = cnt >= TERM;

`ifdef VSLC_SINGLE_STEP_EN
  // step_mode marks a scan started by step_req; it ends in IDLE
  always_ff @(posedge CLK) begin
    if (RST)
      step_mode <= 1'b0;
    else if (state == IDLE)
      step_mode <= !run && step_req;
  end
`else
  logic unused_step;
  assign unused_step = step_req;
  assign step_mode   = 1'b0;
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (run)
          nxt = SAMPLE;
`ifdef VSLC_SINGLE_STEP_EN
        else if (step_req)
          nxt = SAMPLE;
`endif
      end
      SAMPLE: nxt = STROBE;
      STROBE: nxt = EXEC;
      EXEC: begin
        if (instr_done)
          nxt = (pc == LAST) ? COMMIT : STROBE;
      end
      COMMIT: begin
        if (step_mode)
          nxt = IDLE;
        else if (late)
          nxt = run ? SAMPLE : IDLE;
        else
          nxt = WAIT;
      end
      WAIT: begin
        if (cnt == TERM)
          nxt = run ? SAMPLE : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      cnt            <= '0;
      pc             <= '0;
      in_latched     <= '0;
      scan_cycle_clk <= 1'b0;
      scan_overrun   <= 1'b0;
    end else begin
      state <= nxt;
      // counter reads 0 in the SAMPLE cycle itself
      if (nxt == SAMPLE) begin
        cnt            <= '0;
        scan_cycle_clk <= ~scan_cycle_clk;
      end else if (state != IDLE && cnt != '1) begin
        cnt <= cnt + PERIOD_W'(1);
      end
      if (state == SAMPLE) begin
        in_latched <= in_pins;
        pc         <= '0;
      end
      if (state == EXEC && instr_done && pc != LAST)
        pc <= pc + ADDR_W'(1);
      if (state == COMMIT && !step_mode && late)
        scan_overrun <= 1'b1;
    end
  end

  assign addr_strobe  = state == STROBE;
  assign out_latch_en = state == COMMIT;
  assign busy         = state != IDLE;

endmodule

// File: tb/tb_vslc_scan_sequencer.sv
// Scoreboard bench for vslc_scan_sequencer (PROG_LEN=4, SCAN_PERIOD=20).
// Single-step section runs only when VSLC_SINGLE_STEP_EN is defined.
module tb_vslc_scan_sequencer;

  localparam int AW = 4;
  localparam int PL = 4;
  localparam int PW = 16;
  localparam int SP = 20;

  logic          CLK = 0;
  logic          RST = 1;
  logic          run = 0;
  logic          step_req = 0;
  logic          instr_done = 0;
  logic [7:0]    in_pins = 0;
  logic [7:0]    in_latched;
  logic [AW-1:0] pc;
  logic          addr_strobe;
  logic          out_latch_en;
  logic          scan_cycle_clk;
  logic          scan_overrun;
  logic          busy;

  vslc_scan_sequencer #(
    .ADDR_W(AW), .PROG_LEN(PL),
    .PERIOD_W(PW), .SCAN_PERIOD(SP)
  ) dut (
    .CLK(CLK), .RST(RST), .run(run),
    .step_req(step_req), .in_pins(in_pins),
    .instr_done(instr_done),
    .in_latched(in_latched), .pc(pc),
    .addr_strobe(addr_strobe),
    .out_latch_en(out_latch_en),
    .scan_cycle_clk(scan_cycle_clk),
    .scan_overrun(scan_overrun),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int lat = 2;
  int commits = 0;
  int c0 = 0;
  int exp_pc[$];
  logic [7:0] exp_in[$];
  int samp[$];
  int com[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, got, want);
    end
  endtask

  task automatic push_scan(input logic [7:0] v);
    for (int i = 0; i < PL; i++)
      exp_pc.push_back(i);
    exp_in.push_back(v);
  endtask

  task automatic wait_strobe(input int p,
                             input int budget);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!(addr_strobe && pc == p)
               && k < budget);
    chk("strobe_tmo",
        32'(addr_strobe && pc == p), 1);
  endtask

  task automatic wait_latch(input int budget);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!out_latch_en && k < budget);
    chk("latch_tmo", 32'(out_latch_en), 1);
  endtask

  task automatic wait_idle(input string tag,
                           input int budget);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (busy && k < budget);
    chk(tag, 32'(busy), 0);
  endtask

  task automatic chk_zero(input string pre);
    chk({pre, "_busy"}, 32'(busy), 0);
    chk({pre, "_strobe"}, 32'(addr_strobe), 0);
    chk({pre, "_latch"}, 32'(out_latch_en), 0);
    chk({pre, "_pc"}, 32'(pc), 0);
    chk({pre, "_in"}, 32'(in_latched), 0);
    chk({pre, "_sck"}, 32'(scan_cycle_clk), 0);
    chk({pre, "_ovr"}, 32'(scan_overrun), 0);
  endtask

  // core model: instr_done lat cycles after each strobe
  initial begin
    forever begin
      @(negedge CLK);
      instr_done = 0;
      if (addr_strobe) begin
        for (int i = 0; i < lat; i++) begin
          @(negedge CLK);
          if (!busy) break;
        end
        if (busy) instr_done = 1;
      end
    end
  end

  // scoreboard consumer
  initial begin
    logic prev_sck;
    prev_sck = 0;
    forever begin
      @(negedge CLK);
      if (busy && scan_cycle_clk !== prev_sck)
        samp.push_back(cyc);
      prev_sck = scan_cycle_clk;
      if (addr_strobe || out_latch_en)
        chk("excl",
            32'(addr_strobe & out_latch_en), 0);
      if (addr_strobe) begin
        if (exp_pc.size() == 0) begin
          chk("strobe_unexp", exp_pc.size(), 1);
        end else begin
          chk("pc", 32'(pc), exp_pc.pop_front());
          if (exp_in.size() != 0)
            chk("in_latched", 32'(in_latched),
                32'(exp_in[0]));
        end
      end
      if (out_latch_en) begin
        commits++;
        com.push_back(cyc);
        chk("pc_hold", 32'(pc), PL - 1);
        if (exp_in.size() != 0)
          exp_in.delete(0);
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk_zero("rst");

    // timing, input freeze, run drop
    lat = 2;
    in_pins = 8'hA5;
    push_scan(8'hA5);
    push_scan(8'h3C);
    push_scan(8'h3C);
    RST = 0;
    run = 1;
    wait_strobe(1, 50);
    in_pins = 8'h3C;
    wait_latch(100);
    wait_latch(100);
    wait_strobe(2, 50);
    run = 0;
    wait_idle("drop_idle", 100);
    chk("scans", commits, 3);
    chk("q_empty", exp_pc.size(), 0);
    chk("samp_n", samp.size(), 3);
    chk("period1", samp[1] - samp[0], SP);
    chk("period2", samp[2] - samp[1], SP);
    chk("ovr0", 32'(scan_overrun), 0);
    repeat (30) @(negedge CLK);
    chk("stay_idle", 32'(busy), 0);

    // overrun then reset mid-scan
    samp.delete();
    com.delete();
    lat = 8;
    in_pins = 8'h5A;
    push_scan(8'h5A);
    push_scan(8'h5A);
    run = 1;
    wait_latch(100);
    @(negedge CLK);
    chk("ovr_set", 32'(scan_overrun), 1);
    wait_strobe(2, 100);
    chk("ovr_sticky", 32'(scan_overrun), 1);
    chk("ovr_gap", samp[1] - samp[0],
        2 + PL * (lat + 1));
    chk("ovr_b2b", samp[1] - com[0], 1);
    chk("q_left", exp_pc.size(), 1);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    chk_zero("mid");
    RST = 0;
    exp_pc.delete();
    exp_in.delete();
    push_scan(8'h5A);
    wait_strobe(0, 20);
    run = 0;
    wait_idle("ovr_idle", 100);
    chk("ovr_again", 32'(scan_overrun), 1);
    chk("q_empty2", exp_pc.size(), 0);

`ifdef VSLC_SINGLE_STEP_EN
    RST = 1;
    @(negedge CLK);
    RST = 0;
    lat = 1;
    c0 = commits;
    push_scan(8'h5A);
    step_req = 1;
    @(negedge CLK);
    step_req = 0;
    wait_strobe(1, 20);
    step_req = 1;
    @(negedge CLK);
    step_req = 0;
    wait_latch(50);
    @(negedge CLK);
    chk("step_nowait", 32'(busy), 0);
    repeat (30) @(negedge CLK);
    chk("step_one", commits - c0, 1);
    chk("step_q", exp_pc.size(), 0);
    chk("step_idle", 32'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/vslc_scan_sequencer.md
Name: vslc_scan_sequencer

Overview:
- Sequences the VSLC core's scan cycle: latches inputs, steps the program counter through the program one instruction at a time with a strobe/done handshake, commits outputs, then waits out a fixed scan period.
- Sits between the board wrapper and the core, and sources addr_strobe and scan_cycle_clk for the core and the board LEDs.
- Flags scans that overrun their period.

Parameters:
- ADDR_W, 4, program counter width.
- PROG_LEN, 16, number of instructions per scan. Legal range 1..2^ADDR_W.
- PERIOD_W, 16, scan period counter width.
- SCAN_PERIOD, 1000, scan period in CLK cycles, measured from SAMPLE entry to the next SAMPLE entry. Legal range 2..2^PERIOD_W-1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- run  in  1  level; 1 = scan continuously.
- step_req  in  1  single-cycle pulse; requests one scan (optional feature only).
- in_pins  in  8  raw input pins.
- instr_done  in  1  core pulse: current instruction finished.
- in_latched  out  8  input image, frozen for the whole scan.
- pc  out  ADDR_W  current instruction address.
- addr_strobe  out  1  1-cycle pulse: pc is valid, core may fetch.
- out_latch_en  out  1  1-cycle pulse: core copies its output image to pins.
- scan_cycle_clk  out  1  toggles on every SAMPLE entry.
- scan_overrun  out  1  sticky overrun flag.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, period counter 0.
- While RST is high, every register takes its reset value on each CLK edge, including mid-scan. No partial scan resumes after reset.
- States: IDLE, SAMPLE, STROBE, EXEC, COMMIT, WAIT.
- IDLE: run=1 -> SAMPLE next cycle.
- SAMPLE (1 cycle):
  - in_latched <= in_pins; pc <= 0; period counter <= 0.
  - scan_cycle_clk toggles.
  - -> STROBE.
- STROBE (1 cycle): addr_strobe=1 -> EXEC.
- EXEC: wait for instr_done.
  - On instr_done with pc == PROG_LEN-1 -> COMMIT.
  - On instr_done otherwise: pc <= pc+1 -> STROBE.
  - instr_done outside EXEC is ignored.
- COMMIT (1 cycle): out_latch_en=1. pc holds its last value.
  - Period counter already >= SCAN_PERIOD-1 -> set scan_overrun; go to SAMPLE if run=1, else IDLE.
  - Otherwise -> WAIT.
- WAIT: when period counter == SCAN_PERIOD-1, go to SAMPLE if run=1, else IDLE.
- Period counter:
  - Increments every cycle from SAMPLE onward and saturates at 2^PERIOD_W-1; it never wraps.
  - In the non-overrun case, SAMPLE-to-SAMPLE spacing is exactly SCAN_PERIOD cycles.
- run is sampled only in IDLE, COMMIT (overrun path) and WAIT. Deasserting run mid-scan finishes the scan through COMMIT, then goes to IDLE.
- Minimum scan with instr_done returned in the cycle after the strobe: 1 + 2*PROG_LEN + 1 cycles.
- scan_overrun clears only on RST.
- addr_strobe and out_latch_en are never high in the same cycle.

Optional Feature:
- Macro: VSLC_SINGLE_STEP_EN.
- With the macro:
  - In IDLE with run=0, a step_req pulse starts exactly one scan.
  - After COMMIT the block returns to IDLE directly: WAIT is skipped and no overrun check is made.
  - A step_req arriving while busy is dropped.
  - If run=1, it takes priority and step_req is ignored.
- Without the macro: step_req is unused and the block scans only under run.

Test Plan:
- Scan timing. Set PROG_LEN=4, SCAN_PERIOD=20, instr_done 2 cycles after each strobe, run=1 held. Required: 4 addr_strobe pulses with pc=0,1,2,3; one out_latch_en; SAMPLE entries 20 cycles apart; scan_cycle_clk toggles every 20 cycles; scan_overrun stays 0.
- Input freeze. Set in_pins=0xA5 at SAMPLE, then change it to 0x3C mid-EXEC. Required: in_latched stays 0xA5 until the next SAMPLE, then reads 0x3C.
- Overrun. Same PROG_LEN=4, SCAN_PERIOD=20, but instr_done 8 cycles after each strobe. Required: scan_overrun=1 after the first COMMIT; the next SAMPLE follows COMMIT immediately; the flag stays 1 for later scans.
- Run drop. Deassert run during pc=2. Required: pc=3 still strobed, out_latch_en pulses, then IDLE with busy=0 and no further strobes.
- Reset mid-scan. Assert RST for 1 cycle during EXEC at pc=2. Required: next cycle all outputs 0 including scan_overrun, state IDLE. With run=1 the next scan begins with pc=0.
- Single step (VSLC_SINGLE_STEP_EN defined, run=0). Pulse step_req once. Required: exactly one full scan (4 strobes, 1 out_latch_en), then IDLE with no WAIT phase. A second step_req pulsed while busy produces no extra scan.
